// File: rtl/mem_init_pkg.sv
// Shared types and defaults for the memory-controller bring-up sequencer.
package mem_init_pkg;

  localparam int unsigned CntW     = 24;
  localparam int unsigned StateW   = 3;
  localparam int unsigned RetryW   = 2;

  localparam int unsigned DefResetCycles = 16;
  localparam int unsigned DefLockTimeout = 1 << 20;
  localparam int unsigned DefCalibTimeout = 1 << 22;
  localparam int unsigned DefMaxRetry    = 3;

  typedef logic [CntW-1:0]   cnt_t;
  typedef logic [RetryW-1:0] retry_t;

  typedef enum logic [StateW-1:0] {
    StIdle      = 3'd0,
    StReset     = 3'd1,
    StWaitLock  = 3'd2,
    StWaitCalib = 3'd3,
    StRun       = 3'd4,
    StFail      = 3'd5
  } state_e;

endpackage

// File: rtl/mem_init_sequencer_if.sv
// Status inputs and control/debug outputs of the memory bring-up sequencer.
interface mem_init_sequencer_if;
  import mem_init_pkg::*;

  logic                clock_ok;
  logic                mmcm_locked;
  logic                calib_complete;
  logic                restart;
  logic                mem_reset;
  logic                mem_ok;
  logic                init_fail;
  logic [RetryW-1:0]   retry_count;
  logic [StateW-1:0]   state;

  modport master (
    input  clock_ok,
    input  mmcm_locked,
    input  calib_complete,
    input  restart,
    output mem_reset,
    output mem_ok,
    output init_fail,
    output retry_count,
    output state
  );

  modport slave (
    output clock_ok,
    output mmcm_locked,
    output calib_complete,
    output restart,
    input  mem_reset,
    input  mem_ok,
    input  init_fail,
    input  retry_count,
    input  state
  );

endinterface

// File: rtl/sync_3ff.sv
// Three-flop single-bit synchroniser with asynchronous clear.
module sync_3ff (
  input  logic clock,
  input  logic sys_reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [2:0] ff_q;

  always_ff @(posedge clock or posedge sys_reset) begin
    if (sys_reset) begin
      ff_q <= 3'b000;
    end else begin
      ff_q <= {ff_q[1:0], d};
    end
  end

  assign q = ff_q[2];

endmodule

// File: rtl/mem_init_sequencer.sv
// Sequences MIG reset, MMCM lock and calibration, retrying on timeout or loss.
module mem_init_sequencer
  import mem_init_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = DefResetCycles,
  parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned CALIB_TIMEOUT = DefCalibTimeout,
  parameter int unsigned MAX_RETRY     = DefMaxRetry
) (
  input logic                 clock,
  input logic                 sys_reset,
  mem_init_sequencer_if.master bus
);

  localparam cnt_t   ResetLast = CntW'(RESET_CYCLES - 1);
  localparam cnt_t   LockLast  = CntW'(LOCK_TIMEOUT - 1);
  localparam cnt_t   CalibLast = CntW'(CALIB_TIMEOUT - 1);
  localparam retry_t RetryMax  = RetryW'(MAX_RETRY);

  logic clock_ok_s, mmcm_locked_s, calib_complete_s;

  sync_3ff u_sync_clock_ok (
    .clock     (clock),
    .sys_reset (sys_reset),
    .d         (bus.clock_ok),
    .q         (clock_ok_s)
  );

  sync_3ff u_sync_mmcm_locked (
    .clock     (clock),
    .sys_reset (sys_reset),
    .d         (bus.mmcm_locked),
    .q         (mmcm_locked_s)
  );

  sync_3ff u_sync_calib_complete (
    .clock     (clock),
    .sys_reset (sys_reset),
    .d         (bus.calib_complete),
    .q         (calib_complete_s)
  );

  state_e state_q, state_d;
  cnt_t   cnt_q;
  retry_t retry_q, retry_d;
  logic   cnt_clr;
  logic   do_retry;
  logic   mem_reset_q, mem_ok_q, init_fail_q;

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    cnt_clr  = 1'b0;
    do_retry = 1'b0;

    // Priority: clock loss, then restart, then timeout/loss, then progress.
    if (!clock_ok_s && (state_q != StFail)) begin
      state_d = StIdle;
    end else if (bus.restart && (state_q != StIdle)) begin
      state_d = StReset;
      retry_d = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clock_ok_s) state_d = StReset;
        end
        StReset: begin
          if (cnt_q == ResetLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (cnt_q == LockLast) do_retry = 1'b1;
          else if (mmcm_locked_s) state_d = StWaitCalib;
        end
        StWaitCalib: begin
          if (!mmcm_locked_s || (cnt_q == CalibLast)) do_retry = 1'b1;
          else if (calib_complete_s) state_d = StRun;
        end
        StRun: begin
          if (!mmcm_locked_s || !calib_complete_s) do_retry = 1'b1;
        end
        StFail: begin
          state_d = StFail;
        end
        default: state_d = StIdle;
      endcase

      if (do_retry) begin
        if (retry_q == RetryMax) begin
          state_d = StFail;
        end else begin
          state_d = StReset;
          retry_d = retry_q + retry_t'(1);
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change in step with state.
  always_ff @(posedge clock or posedge sys_reset) begin
    if (sys_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      retry_q     <= '0;
      mem_reset_q <= 1'b1;
      mem_ok_q    <= 1'b0;
      init_fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if ((state_d != state_q) || cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + cnt_t'(1);
      end
      mem_reset_q <= (state_d == StIdle) || (state_d == StReset) || (state_d == StFail);
      mem_ok_q    <= (state_d == StRun);
      init_fail_q <= (state_d == StFail);
    end
  end

  assign bus.mem_reset   = mem_reset_q;
  assign bus.mem_ok      = mem_ok_q;
  assign bus.init_fail   = init_fail_q;
  assign bus.retry_count = retry_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mem_init_sequencer.sv
// Scoreboard bench: stimulus queues the expected output changes with their cycle numbers.
module tb_mem_init_sequencer;
  import mem_init_pkg::*;

  logic clock = 1'b0;
  logic sys_reset = 1'b1;
  int   cyc = 0;
  bit   finish_req = 1'b0;

  mem_init_sequencer_if bus ();

  mem_init_sequencer #(
    .RESET_CYCLES  (16),
    .LOCK_TIMEOUT  (64),
    .CALIB_TIMEOUT (256),
    .MAX_RETRY     (3)
  ) dut (
    .clock     (clock),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [2:0]  st;
    logic        rst;
    logic        ok;
    logic        fail;
    logic [1:0]  rc;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input int at, input state_e st, input logic rst, input logic ok,
                      input logic fail, input logic [1:0] rc, input string name);
    exp_t e;
    e.at = at; e.st = st; e.rst = rst; e.ok = ok; e.fail = fail; e.rc = rc; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every change of the output vector must match the next queued expectation.
  initial begin : monitor
    int n_tests = 0;
    int n_fail = 0;
    bit seen = 1'b0;
    logic [7:0] obs, prev, want;
    exp_t e;
    forever begin
      @(negedge clock);
      if (finish_req) begin
        n_tests++;
        if (sb_q.size() != 0) begin
          n_fail++;
          $display("FAIL leftover_expectations: got %0d pending (next %s), required 0",
                   sb_q.size(), sb_q[0].name);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      obs = {bus.state, bus.mem_reset, bus.mem_ok, bus.init_fail, bus.retry_count};
      if (!seen || (obs !== prev)) begin
        seen = 1'b1;
        prev = obs;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got st/rst/ok/fail/rc=%b at cycle %0d, required none",
                   obs, cyc);
        end else begin
          e = sb_q.pop_front();
          want = {e.st, e.rst, e.ok, e.fail, e.rc};
          if ((obs !== want) || ((e.at >= 0) && (e.at != cyc))) begin
            n_fail++;
            $display("FAIL %s: got st/rst/ok/fail/rc=%b at cycle %0d, required %b at cycle %0d",
                     e.name, obs, cyc, want, e.at);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int t;
    int b;
    bus.clock_ok       = 1'b0;
    bus.mmcm_locked    = 1'b0;
    bus.calib_complete = 1'b0;
    bus.restart        = 1'b0;
    push(-1, StIdle, 1, 0, 0, 0, "reset_state");
    at_cycle(3);
    sys_reset = 1'b0;

    // Clean bring-up: async inputs take 3 sync flops + 1 state register.
    at_cycle(5);
    t = cyc;
    push(t + 4,  StReset,     1, 0, 0, 0, "bringup_reset");
    push(t + 20, StWaitLock,  0, 0, 0, 0, "bringup_reset_16");
    push(t + 34, StWaitCalib, 0, 0, 0, 0, "bringup_lock");
    push(t + 84, StRun,       0, 1, 0, 0, "bringup_mem_ok");
    bus.clock_ok = 1'b1;
    at_cycle(t + 30);
    bus.mmcm_locked = 1'b1;
    at_cycle(t + 80);
    bus.calib_complete = 1'b1;

    // One-cycle calibration drop while running.
    at_cycle(t + 100);
    t = cyc;
    push(t + 4,  StReset,     1, 0, 0, 1, "run_loss_retry");
    push(t + 20, StWaitLock,  0, 0, 0, 1, "run_loss_reset_16");
    push(t + 21, StWaitCalib, 0, 0, 0, 1, "run_loss_relock");
    push(t + 22, StRun,       0, 1, 0, 1, "run_loss_recover");
    bus.calib_complete = 1'b0;
    at_cycle(t + 1);
    bus.calib_complete = 1'b1;

    // Restart from RUN clears retries, then lock never arrives: four timeouts to FAIL.
    at_cycle(t + 40);
    t = cyc;
    push(t + 1, StReset, 1, 0, 0, 0, "restart_in_run");
    b = t + 17;
    for (int i = 0; i < 4; i++) begin
      push(b, StWaitLock, 0, 0, 0, 2'(i), "lock_wait_entry");
      if (i < 3) push(b + 64, StReset, 1, 0, 0, 2'(i + 1), "lock_timeout_retry");
      else       push(b + 64, StFail,  1, 0, 1, 2'd3,      "lock_timeout_fail");
      b += 80;
    end
    bus.restart        = 1'b1;
    bus.mmcm_locked    = 1'b0;
    bus.calib_complete = 1'b0;
    at_cycle(t + 1);
    bus.restart = 1'b0;

    // Restart out of FAIL, one lock timeout, then lock into WAIT_CALIB.
    at_cycle(t + 340);
    t = cyc;
    push(t + 1,   StReset,     1, 0, 0, 0, "restart_from_fail");
    push(t + 17,  StWaitLock,  0, 0, 0, 0, "post_fail_wait_lock");
    push(t + 81,  StReset,     1, 0, 0, 1, "post_fail_timeout");
    push(t + 97,  StWaitLock,  0, 0, 0, 1, "post_fail_wait_lock2");
    push(t + 104, StWaitCalib, 0, 0, 0, 1, "post_fail_lock");
    bus.restart = 1'b1;
    at_cycle(t + 1);
    bus.restart = 1'b0;
    at_cycle(t + 100);
    bus.mmcm_locked = 1'b1;

    // Restart is delayed 3 cycles so it meets the synchronised clock_ok drop.
    at_cycle(t + 110);
    t = cyc;
    push(t + 4, StIdle, 1, 0, 0, 1, "clk_loss_beats_restart");
    bus.clock_ok = 1'b0;
    at_cycle(t + 3);
    bus.restart = 1'b1;
    at_cycle(t + 4);
    bus.restart = 1'b0;
    at_cycle(t + 10);
    bus.restart = 1'b1;
    at_cycle(t + 11);
    bus.restart = 1'b0;

    // Clock returns with retry count kept; calibration then times out once.
    at_cycle(t + 20);
    t = cyc;
    push(t + 4,   StReset,     1, 0, 0, 1, "clk_return_keeps_retry");
    push(t + 20,  StWaitLock,  0, 0, 0, 1, "clk_return_wait_lock");
    push(t + 21,  StWaitCalib, 0, 0, 0, 1, "clk_return_lock");
    push(t + 277, StReset,     1, 0, 0, 2, "calib_timeout_retry");
    push(t + 293, StWaitLock,  0, 0, 0, 2, "calib_retry_wait_lock");
    push(t + 294, StWaitCalib, 0, 0, 0, 2, "calib_retry_lock");
    push(t + 295, StRun,       0, 1, 0, 2, "calib_retry_run");
    bus.clock_ok = 1'b1;
    at_cycle(t + 280);
    bus.calib_complete = 1'b1;

    // sys_reset pulse in RUN, then full re-bring-up from IDLE.
    at_cycle(t + 310);
    t = cyc;
    push(t,      StIdle,      1, 0, 0, 0, "sys_reset_in_run");
    push(t + 6,  StReset,     1, 0, 0, 0, "after_reset_reset");
    push(t + 22, StWaitLock,  0, 0, 0, 0, "after_reset_wait_lock");
    push(t + 23, StWaitCalib, 0, 0, 0, 0, "after_reset_lock");
    push(t + 24, StRun,       0, 1, 0, 0, "after_reset_run");
    sys_reset = 1'b1;
    at_cycle(t + 2);
    sys_reset = 1'b0;

    at_cycle(t + 40);
    finish_req = 1'b1;
  end

endmodule

// File: doc/mem_init_sequencer.md
MEM_INIT_SEQUENCER -- requirements
Module: mem_init_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 16, SHALL set the mem_reset assertion length in cycles (range 2..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 2^20, SHALL set the maximum cycles spent waiting for mmcm_locked (range 2..2^24).
REQ-003 Parameter CALIB_TIMEOUT, default 2^22, SHALL set the maximum cycles spent waiting for calib_complete (range 2..2^24).
REQ-004 Parameter MAX_RETRY, default 3, SHALL set the number of re-initialisation attempts before failure (range 0..3).
REQ-005 clock  in  1  SHALL be the single 200 MHz clock for all logic.
REQ-006 sys_reset  in  1  SHALL be the reset, asynchronous and active-high.
REQ-007 clock_ok  in  1  SHALL indicate the reference clock is good (asynchronous).
REQ-008 mmcm_locked  in  1  SHALL indicate MIG MMCM lock (asynchronous).
REQ-009 calib_complete  in  1  SHALL indicate DDR calibration done (asynchronous).
REQ-010 restart  in  1  SHALL be a synchronous single-cycle request to re-run initialisation.
REQ-011 mem_reset  out  1  SHALL be the active-high memory controller reset.
REQ-012 mem_ok  out  1  SHALL indicate memory usable.
REQ-013 init_fail  out  1  SHALL indicate retries exhausted.
REQ-014 retry_count  out  2  SHALL report retries consumed since the last clean start.
REQ-015 state  out  3  SHALL expose the current FSM state encoding for debug.

Function
REQ-016 clock_ok, mmcm_locked and calib_complete SHALL each pass through a 3-flop synchroniser before use (_s suffix below); response latency SHALL be 3 cycles sync plus 1 cycle state register.
REQ-017 States SHALL be IDLE=0, RESET=1, WAIT_LOCK=2, WAIT_CALIB=3, RUN=4, FAIL=5; all outputs SHALL be registered and decoded from state.
REQ-018 IDLE: mem_reset=1; clock_ok_s=1 -> RESET with the cycle counter cleared.
REQ-019 RESET: mem_reset=1; counter increments each cycle; counter==RESET_CYCLES-1 -> WAIT_LOCK with the counter cleared, giving exactly RESET_CYCLES cycles in RESET.
REQ-020 WAIT_LOCK: mem_reset=0; mmcm_locked_s=1 -> WAIT_CALIB with the counter cleared; counter==LOCK_TIMEOUT-1 -> RETRY action.
REQ-021 WAIT_CALIB: mem_reset=0; calib_complete_s=1 with mmcm_locked_s=1 -> RUN; mmcm_locked_s=0 or counter==CALIB_TIMEOUT-1 -> RETRY action.
REQ-022 RUN: mem_ok=1 and mem_reset=0; mmcm_locked_s=0 or calib_complete_s=0 -> RETRY action.
REQ-023 RETRY action: if retry_count==MAX_RETRY -> FAIL; else retry_count+1 -> RESET with the counter cleared.
REQ-024 FAIL: mem_reset=1, init_fail=1, mem_ok=0; FAIL SHALL exit only on restart.
REQ-025 restart in any state except IDLE SHALL clear retry_count and init_fail and go to RESET; restart in IDLE SHALL be ignored.
REQ-026 clock_ok_s=0 in any state except FAIL SHALL go to IDLE with retry_count preserved.
REQ-027 Priority for simultaneous events SHALL be clock_ok_s loss > restart > timeout/loss > progress.
REQ-028 mem_ok SHALL be 1 only in RUN; mem_reset SHALL be 1 in IDLE, RESET and FAIL.
REQ-029 The cycle counter SHALL be 24 bits, cleared on every state change, and SHALL never wrap in any state.
REQ-030 retry_count SHALL never exceed MAX_RETRY.

Reset
REQ-031 During sys_reset: state=IDLE, counter=0, retry_count=0, mem_reset=1, mem_ok=0, init_fail=0, and all synchroniser flops=0.
REQ-032 sys_reset deassertion mid-sequence SHALL restart from IDLE; no state SHALL survive reset.

Structure
REQ-033 Package mem_init_pkg SHALL hold the state encodings, the counter width (24) and the default parameter values.
REQ-034 Sub-module sync_3ff (1-bit, ASYNC_REG flops, async reset to 0) SHALL be instantiated three times.

Verification (bench params: RESET_CYCLES=16, LOCK_TIMEOUT=64, CALIB_TIMEOUT=256, MAX_RETRY=3)
REQ-035 Check clean bring-up: raise clock_ok; raise locked 10 cycles after mem_reset falls; raise calib 50 cycles later -> mem_reset high exactly 16 cycles, mem_ok=1 4 cycles after calib, retry_count=0.
REQ-036 Check lock timeout: hold locked=0 -> 64 cycles in WAIT_LOCK, then RESET with retry_count=1; after 4 timeouts -> FAIL, init_fail=1, retry_count=3.
REQ-037 Check loss in RUN: drop calib_complete for 1 cycle -> mem_ok=0 within 4 cycles, mem_reset high 16 cycles, retry_count increments.
REQ-038 Check restart from FAIL: pulse restart -> RESET next cycle, init_fail=0, retry_count=0.
REQ-039 Check simultaneous events: clock_ok drop coincident with restart in WAIT_CALIB -> IDLE with retry_count unchanged; sys_reset pulse in RUN -> all outputs at reset values.
